// File: rtl/chip8_mem_sys_if.sv
// Request/response bundle between the CHIP-8 core/loader and the memory subsystem.
interface chip8_mem_sys_if #(
  parameter int ADDR_W    = 12,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST) + 1
);
  logic                   init_busy;
  logic                   fetch_req;
  logic [ADDR_W-1:0]      fetch_addr;
  logic [15:0]            fetch_data;
  logic                   fetch_valid;
  logic                   burst_req;
  logic                   burst_write;
  logic [ADDR_W-1:0]      burst_addr;
  logic [LEN_W-1:0]       burst_len;
  logic [8*MAX_BURST-1:0] wr_data;
  logic [8*MAX_BURST-1:0] rd_data;
  logic                   burst_done;
  logic                   load_we;
  logic [ADDR_W-1:0]      load_addr;
  logic [7:0]             load_data;
  logic                   load_ack;

  modport master (
    input  init_busy, fetch_data, fetch_valid, rd_data, burst_done, load_ack,
    output fetch_req, fetch_addr, burst_req, burst_write, burst_addr, burst_len,
           wr_data, load_we, load_addr, load_data
  );
  modport slave (
    output init_busy, fetch_data, fetch_valid, rd_data, burst_done, load_ack,
    input  fetch_req, fetch_addr, burst_req, burst_write, burst_addr, burst_len,
           wr_data, load_we, load_addr, load_data
  );
endinterface

// File: rtl/chip8_mem_sys.sv
// CHIP-8 main memory: single-port byte RAM sequenced between font preload,
// instruction fetch, register bursts and host ROM loading.
module chip8_mem_sys #(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int FONT_BASE = 0,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
  input logic            clock,
  input logic            resetN,
  chip8_mem_sys_if.slave bus
);
  localparam logic [7:0] FONT [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_FHI, S_FLO, S_FOUT, S_BURST, S_BWAIT, S_BFIN, S_LOAD
  } state_t;

  function automatic logic [ADDR_W-1:0] wrap(input logic [31:0] x);
    return ADDR_W'(x % 32'(DEPTH));
  endfunction

  state_t                 state_q, state_d;
  logic [6:0]             cnt_q;
  logic [ADDR_W-1:0]      f_addr_q, b_addr_q, l_addr_q;
  logic [7:0]             l_data_q, hi_q, ram_q;
  logic                   b_wr_q;
  logic [LEN_W-1:0]       b_len_q, idx_q, cap_idx_q, len_eff;
  logic [8*MAX_BURST-1:0] b_wdata_q, rd_data_q;
  logic                   cap_vld_q;
  logic [15:0]            fetch_data_q;
  logic                   fetch_valid_q, burst_done_q, load_ack_q;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_addr;
  logic [7:0]             ram_wdata;
  logic [7:0]             mem [DEPTH];

  assign len_eff = (bus.burst_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.burst_len;

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = wrap(32'(FONT_BASE) + 32'(cnt_q));
        ram_wdata = FONT[cnt_q];
        if (cnt_q == 7'd79) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.fetch_req)      state_d = S_FHI;
        else if (bus.burst_req) state_d = (len_eff == '0) ? S_BFIN : S_BURST;
        else if (bus.load_we)   state_d = S_LOAD;
      end
      S_FHI: begin
        ram_addr = f_addr_q;
        state_d  = S_FLO;
      end
      S_FLO: begin
        ram_addr = wrap(32'(f_addr_q) + 32'd1);
        state_d  = S_FOUT;
      end
      S_FOUT: state_d = S_IDLE;
      S_BURST: begin
        ram_addr  = wrap(32'(b_addr_q) + 32'(idx_q));
        ram_we    = b_wr_q;
        ram_wdata = b_wdata_q[8*idx_q +: 8];
        if (idx_q == b_len_q - LEN_W'(1)) state_d = S_BWAIT;
      end
      S_BWAIT: state_d = S_BFIN;
      S_BFIN:  state_d = S_IDLE;
      S_LOAD: begin
        ram_we    = 1'b1;
        ram_addr  = l_addr_q;
        ram_wdata = l_data_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // RAM is never reset; writes are gated so a held reset cannot disturb contents.
  always_ff @(posedge clock) begin
    if (ram_we && resetN) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      f_addr_q      <= '0;
      b_addr_q      <= '0;
      l_addr_q      <= '0;
      l_data_q      <= '0;
      hi_q          <= '0;
      b_wr_q        <= 1'b0;
      b_len_q       <= '0;
      idx_q         <= '0;
      cap_idx_q     <= '0;
      cap_vld_q     <= 1'b0;
      b_wdata_q     <= '0;
      rd_data_q     <= '0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      burst_done_q  <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= 1'b0;
      burst_done_q  <= 1'b0;
      load_ack_q    <= 1'b0;
      cap_vld_q     <= 1'b0;
      // read data lands in ram_q one clock after the address; store it then
      if (cap_vld_q) rd_data_q[8*cap_idx_q +: 8] <= ram_q;
      case (state_q)
        S_INIT: cnt_q <= cnt_q + 7'd1;
        S_IDLE: begin
          if (bus.fetch_req) begin
            f_addr_q <= wrap(32'(bus.fetch_addr));
          end else if (bus.burst_req) begin
            b_addr_q  <= wrap(32'(bus.burst_addr));
            b_wr_q    <= bus.burst_write;
            b_len_q   <= len_eff;
            b_wdata_q <= bus.wr_data;
            idx_q     <= '0;
          end else if (bus.load_we) begin
            l_addr_q <= wrap(32'(bus.load_addr));
            l_data_q <= bus.load_data;
          end
        end
        S_FLO: hi_q <= ram_q;
        S_FOUT: begin
          fetch_data_q  <= {hi_q, ram_q};
          fetch_valid_q <= 1'b1;
        end
        S_BURST: begin
          idx_q <= idx_q + LEN_W'(1);
          if (!b_wr_q) begin
            cap_vld_q <= 1'b1;
            cap_idx_q <= idx_q;
          end
        end
        S_BFIN: burst_done_q <= 1'b1;
        S_LOAD: load_ack_q   <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.init_busy   = (state_q == S_INIT);
  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.load_ack    = load_ack_q;
endmodule

// File: tb/tb_chip8_mem_sys.sv
// Directed bench for chip8_mem_sys: font preload, fetch, bursts, loads,
// arbitration order and reset abort.
module tb_chip8_mem_sys;
  logic clock, resetN;
  int   n_chk, n_fail;
  logic [127:0] exp_rd, wd;

  chip8_mem_sys_if #(.ADDR_W(12), .MAX_BURST(16)) bus ();
  chip8_mem_sys dut (.clock(clock), .resetN(resetN), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_chk(input logic [11:0] a, input logic [15:0] exp, input string tag);
    int k;
    k = 0;
    bus.fetch_addr = a;
    bus.fetch_req  = 1'b1;
    do begin tick(); k++; end while (!bus.fetch_valid && k < 50);
    bus.fetch_req = 1'b0;
    check({tag, "_lat"}, 128'(k - 1), 128'd3);
    check({tag, "_data"}, 128'(bus.fetch_data), 128'(exp));
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d, input string tag);
    int k;
    k = 0;
    bus.load_addr = a;
    bus.load_data = d;
    bus.load_we   = 1'b1;
    do begin tick(); k++; end while (!bus.load_ack && k < 300);
    bus.load_we = 1'b0;
    check({tag, "_lat"}, 128'(k - 1), 128'd1);
  endtask

  task automatic burst(input logic wr, input logic [11:0] a, input logic [4:0] len,
                       input logic [127:0] data, input int lat, input string tag);
    int k;
    k = 0;
    bus.burst_write = wr;
    bus.burst_addr  = a;
    bus.burst_len   = len;
    bus.wr_data     = data;
    bus.burst_req   = 1'b1;
    do begin tick(); k++; end while (!bus.burst_done && k < 60);
    bus.burst_req = 1'b0;
    check({tag, "_lat"}, 128'(k - 1), 128'(lat));
  endtask

  initial begin
    int n, spur, fk, bk, lk, ov;
    logic [15:0] fd;
    n_chk = 0; n_fail = 0;
    resetN = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.burst_req = 1'b0; bus.burst_write = 1'b0; bus.burst_addr = '0;
    bus.burst_len = '0; bus.wr_data = '0;
    bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;

    // reset state
    tick(); tick();
    check("rst_busy", 128'(bus.init_busy), 128'd1);
    check("rst_fdata", 128'(bus.fetch_data), 128'd0);
    check("rst_rdata", bus.rd_data, 128'd0);
    check("rst_pulses", 128'({bus.fetch_valid, bus.burst_done, bus.load_ack}), 128'd0);
    resetN = 1'b1;

    // font preload takes exactly 80 clocks
    repeat (79) tick();
    check("init_busy_79", 128'(bus.init_busy), 128'd1);
    tick();
    check("init_busy_80", 128'(bus.init_busy), 128'd0);
    fetch_chk(12'h000, 16'hF090, "font0");
    fetch_chk(12'h04B, 16'hF080, "fontF");

    // host loads then fetch, including wrap at top of memory
    load(12'h200, 8'h12, "ld200");
    load(12'h201, 8'h4E, "ld201");
    fetch_chk(12'h200, 16'h124E, "f200");
    load(12'hFFF, 8'hAB, "ldFFF");
    fetch_chk(12'hFFF, 16'hABF0, "fwrap");

    // 16-byte write then read back
    for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(i + 1);
    burst(1'b1, 12'h300, 5'd16, wd, 18, "bw16");
    burst(1'b0, 12'h300, 5'd16, '0, 18, "br16");
    exp_rd = wd;
    check("br16_data", bus.rd_data, exp_rd);

    // short read wrapping past the top, upper bytes retained
    load(12'hFFE, 8'h5C, "ldFFE");
    burst(1'b0, 12'hFFE, 5'd3, '0, 5, "br3");
    exp_rd[23:0] = 24'hF0AB5C;
    check("br3_data", bus.rd_data, exp_rd);

    // zero length: immediate done, RAM untouched
    burst(1'b1, 12'h300, 5'd0, {16{8'hEE}}, 1, "bw0");
    fetch_chk(12'h300, 16'h0102, "bw0_mem");
    check("bw0_rdata", bus.rd_data, exp_rd);

    // over-long length clamps to 16
    load(12'h410, 8'h77, "ld410");
    for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(8'h80 + i);
    burst(1'b1, 12'h400, 5'd20, wd, 18, "bw20");
    fetch_chk(12'h40F, 16'h8F77, "bw20_end");

    // arbitration: fetch, then burst, then load
    fk = 0; bk = 0; lk = 0; ov = 0; fd = '0;
    bus.fetch_addr = 12'h200;
    bus.burst_write = 1'b0; bus.burst_addr = 12'h300; bus.burst_len = 5'd2;
    bus.load_addr = 12'h301; bus.load_data = 8'h99;
    bus.fetch_req = 1'b1; bus.burst_req = 1'b1; bus.load_we = 1'b1;
    for (int t = 1; t <= 60 && lk == 0; t++) begin
      tick();
      if (int'(bus.fetch_valid) + int'(bus.burst_done) + int'(bus.load_ack) > 1) ov++;
      if (bus.fetch_valid) begin fk = t; fd = bus.fetch_data; bus.fetch_req = 1'b0; end
      if (bus.burst_done)  begin bk = t; bus.burst_req = 1'b0; end
      if (bus.load_ack)    begin lk = t; bus.load_we = 1'b0; end
    end
    bus.fetch_req = 1'b0; bus.burst_req = 1'b0; bus.load_we = 1'b0;
    check("arb_fetch_t", 128'(fk), 128'd4);
    check("arb_burst_t", 128'(bk), 128'd9);
    check("arb_load_t", 128'(lk), 128'd11);
    check("arb_overlap", 128'(ov), 128'd0);
    check("arb_fdata", 128'(fd), 128'h124E);
    exp_rd[15:0] = 16'h0201;
    check("arb_rdata", bus.rd_data, exp_rd);
    fetch_chk(12'h300, 16'h0199, "arb_load_mem");

    // reset during clock 5 of a 16-byte write burst
    load(12'h604, 8'h11, "ld604");
    load(12'h605, 8'h22, "ld605");
    load(12'h701, 8'h66, "ld701");
    for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(8'hA0 + i);
    bus.burst_write = 1'b1; bus.burst_addr = 12'h600; bus.burst_len = 5'd16;
    bus.wr_data = wd; bus.burst_req = 1'b1;
    tick();
    repeat (4) tick();
    check("abort_nodone", 128'(bus.burst_done), 128'd0);
    resetN = 1'b0;
    bus.burst_req = 1'b0;
    bus.load_addr = 12'h700; bus.load_data = 8'h55; bus.load_we = 1'b1;
    #3 resetN = 1'b1;
    n = 0; spur = 0;
    while (bus.init_busy && n < 200) begin
      tick(); n++;
      if (bus.load_ack || bus.burst_done || bus.fetch_valid) spur++;
    end
    check("reinit_len", 128'(n), 128'd80);
    check("reinit_noack", 128'(spur), 128'd0);
    check("reinit_rdata", bus.rd_data, 128'd0);
    load(12'h700, 8'h55, "ld_after_init");
    fetch_chk(12'h700, 16'h5566, "ld700_mem");
    fetch_chk(12'h600, 16'hA0A1, "abort_b0");
    fetch_chk(12'h602, 16'hA2A3, "abort_b3");
    fetch_chk(12'h604, 16'h1122, "abort_b4");
    fetch_chk(12'h000, 16'hF090, "refont");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chip8_mem_sys.md
Name: chip8_mem_sys

Overview:
- Parametrised CHIP-8 main memory subsystem: single-port byte RAM behind a sequencing FSM.
- Preloads the 80-byte hex font after every reset, then serves three requesters:
  - the CPU instruction fetch (16-bit, big-endian);
  - multi-byte register bursts (FX55/FX65, FX33);
  - a host load port for ROM images.
- Sits between the CPU core/loader and the RAM array; replaces the flat combinational-init memory.

Parameters:
- ADDR_W, 12: address width.
- DEPTH, 4096: bytes of RAM; all addresses are taken modulo DEPTH.
- FONT_BASE, 0: first byte address of the font table.
- MAX_BURST, 16: maximum bytes per burst.
- LEN_W, $clog2(MAX_BURST)+1: width of burst_len.

Ports:
- clock  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the font preload runs.
- fetch_req  in  1  instruction fetch request; level, held until fetch_valid.
- fetch_addr  in  ADDR_W  address of the high opcode byte.
- fetch_data  out  16  {mem[a], mem[a+1]}.
- fetch_valid  out  1  one-cycle pulse; fetch_data valid.
- burst_req  in  1  burst request; level, held until burst_done.
- burst_write  in  1  1 = write, 0 = read.
- burst_addr  in  ADDR_W  burst start address.
- burst_len  in  LEN_W  byte count, 0..MAX_BURST.
- wr_data  in  8*MAX_BURST  byte i at [8i+:8].
- rd_data  out  8*MAX_BURST  byte i at [8i+:8].
- burst_done  out  1  one-cycle pulse; burst complete.
- load_we  in  1  host byte write request; level, held until load_ack.
- load_addr  in  ADDR_W  host write address.
- load_data  in  8  host write byte.
- load_ack  out  1  one-cycle pulse; byte written.

Behaviour:
- Memory: DEPTH x 8, one access per clock (read or write), synchronous read with data registered one clock after the address. All address arithmetic (a+1, burst_addr+i) wraps modulo DEPTH.
- Reset (async):
  - State goes to INIT.
  - fetch_data=0, rd_data=0, fetch_valid=0, burst_done=0, load_ack=0, init_busy=1.
  - RAM contents outside the font region are not cleared.
- INIT:
  - Writes the standard 80-byte 0-F font (5 bytes per glyph, glyph 0 = F0 90 90 90 F0) to FONT_BASE+k, k=0..79, one byte per clock.
  - Takes exactly 80 clocks, then goes to IDLE with init_busy=0.
  - All requests are ignored during INIT and are not acked.
- IDLE arbitration, checked at each rising edge: fetch_req > burst_req > load_we. Requests are accepted only in IDLE; inputs are sampled and latched at acceptance.
- Fetch:
  - FETCH_HI reads a, FETCH_LO reads a+1, FETCH_OUT presents the result.
  - fetch_valid pulses 3 clocks after the accepting edge, with fetch_data = {mem[a], mem[a+1]}, then IDLE.
  - a = DEPTH-1 wraps the low byte to address 0.
- Burst:
  - Effective length L = min(burst_len, MAX_BURST).
  - Byte i (0..L-1) is accessed at burst_addr+i, one per clock.
  - Write: mem[addr+i] <= wr_data[8i+:8].
  - Read: rd_data[8i+:8] <= mem[addr+i]. Bytes i >= L of rd_data hold their previous value.
  - burst_done pulses L+2 clocks after acceptance, for both read and write.
  - L=0: no memory access; burst_done pulses 1 clock after acceptance.
- Load: mem[load_addr] <= load_data in the clock after acceptance; load_ack pulses in that same clock.
- All completion pulses last exactly 1 cycle and are mutually exclusive.
- A requester that keeps its request high after its ack is re-accepted on the next IDLE edge. A back-to-back fetch therefore has a 4-clock period.
- Reset mid-operation aborts the operation: no ack is issued, RAM bytes already written remain, and INIT restarts.

Test Plan:
- Reset, then wait 80 clocks -> init_busy falls exactly on clock 80; a fetch at 0x000 returns 0xF090; a fetch at 0x04B returns 0xF080.
- Host loads 0x12@0x200 and 0x4E@0x201, then fetch_req at 0x200 -> fetch_valid 3 clocks after acceptance with fetch_data=0x124E. A fetch at 0xFFF with mem[0xFFF]=0xAB and mem[0x000]=0xF0 -> 0xABF0 (wrap).
- Burst write len=16 at 0x300 (byte i = i+1), then burst read len=16 -> rd_data bytes 01..10; burst_done at +18 clocks for each.
- Burst read len=3 at 0xFFE -> bytes {mem[0xFFE], mem[0xFFF], mem[0x000]}, rd_data bytes 3..15 unchanged; len=0 -> burst_done at +1, RAM untouched; len=20 -> clamped to 16.
- fetch_req, burst_req and load_we raised together in IDLE -> fetch serviced first, then burst, then load; no overlapping pulses.
- resetN asserted during clock 5 of a 16-byte write burst -> no burst_done; bytes 0..3 written, bytes 4..15 untouched; INIT reruns for 80 clocks; requests raised during INIT are not acked until init_busy=0.
